// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and defaults for the memory-access stage
package mem_pkg;

  localparam int unsigned DEFAULT_TIMEOUT = 255;

  typedef enum logic {IDLE, WAIT} state_e;

  typedef struct packed {
    logic pcsrc;
    logic regwrite;
    logic memtoreg;
  } wb_ctrl_t;

endpackage

// File: rtl/mem_stage_wait_counter.sv
// rtl/mem_stage_wait_counter.sv - wait-cycle counter with terminal-count compare
module wait_counter
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear_i,
  input  logic start_i,
  input  logic inc_i,
  output logic tc_o
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TC = CW'(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)      cnt_d = '0;
    else if (start_i) cnt_d = CW'(1);
    else if (inc_i)   cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == TC);

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - EX/MEM register, data-memory handshake FSM and MEM/WB register
module mem_stage
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        FlushE,
  input  logic        PCSrcE,
  input  logic        RegWriteE,
  input  logic        MemtoRegE,
  input  logic        MemWriteE,
  input  logic [31:0] ALUResultE,
  input  logic [31:0] WriteDataE,
  input  logic [3:0]  WriteAddrE,
  output logic [31:0] ALUResultM,
  output logic [3:0]  WriteAddrM,
  output logic        RegWriteM,
  output logic        StallM,
  output logic [31:0] DataAdr,
  output logic [31:0] MemWData,
  output logic        MemReq,
  output logic        MemWe,
  input  logic        MemReady,
  input  logic [31:0] ReadData,
  output logic        PCSrcW,
  output logic        RegWriteW,
  output logic        MemtoRegW,
  output logic [31:0] ReadDataW,
  output logic [31:0] ALUOutW,
  output logic [3:0]  WriteAddrW,
  output logic        MemFault
);

  logic        pcsrc_m_q, regwrite_m_q, memtoreg_m_q, memwrite_m_q;
  logic [31:0] alu_m_q, wdata_m_q;
  logic [3:0]  waddr_m_q;

  wb_ctrl_t    wb_q;
  logic [31:0] rdata_w_q, alu_w_q;
  logic [3:0]  waddr_w_q;
  logic        fault_q;

  state_e state_q, state_d;
  logic   cnt_clear, cnt_start, cnt_inc, cnt_tc;
  logic   mem_op, misaligned, abort, kill;

  assign mem_op     = memtoreg_m_q | memwrite_m_q;
  assign misaligned = |alu_m_q[1:0];

  wait_counter #(.TIMEOUT(TIMEOUT)) u_wait_counter (
    .clk     (clk),
    .resetn  (reset),
    .clear_i (cnt_clear),
    .start_i (cnt_start),
    .inc_i   (cnt_inc),
    .tc_o    (cnt_tc)
  );

  always_comb begin
    state_d   = state_q;
    cnt_clear = 1'b0;
    cnt_start = 1'b0;
    cnt_inc   = 1'b0;
    abort     = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op && !misaligned && !MemReady) begin
          state_d   = WAIT;
          cnt_start = 1'b1;
        end
      end
      WAIT: begin
        if (MemReady) begin
          state_d   = IDLE;
          cnt_clear = 1'b1;
        end else if (cnt_tc) begin
          state_d   = IDLE;
          cnt_clear = 1'b1;
          abort     = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // EX/MEM only advances when not stalled, so request fields stay stable while waiting.
  assign MemReq = (state_q == WAIT) | (mem_op & ~misaligned);
  assign StallM = MemReq & ~MemReady & ~abort;
  assign kill   = (mem_op & misaligned) | abort;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pcsrc_m_q    <= 1'b0;
      regwrite_m_q <= 1'b0;
      memtoreg_m_q <= 1'b0;
      memwrite_m_q <= 1'b0;
      alu_m_q      <= '0;
      wdata_m_q    <= '0;
      waddr_m_q    <= '0;
    end else if (!StallM) begin
      pcsrc_m_q    <= PCSrcE & ~FlushE;
      regwrite_m_q <= RegWriteE & ~FlushE;
      memtoreg_m_q <= MemtoRegE & ~FlushE;
      memwrite_m_q <= MemWriteE & ~FlushE;
      alu_m_q      <= ALUResultE;
      wdata_m_q    <= WriteDataE;
      waddr_m_q    <= WriteAddrE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wb_q      <= '0;
      rdata_w_q <= '0;
      alu_w_q   <= '0;
      waddr_w_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      fault_q <= fault_q | kill;
      if (StallM) begin
        wb_q <= '0;
      end else begin
        wb_q <= '{pcsrc: pcsrc_m_q & ~kill, regwrite: regwrite_m_q & ~kill,
                  memtoreg: memtoreg_m_q};
        alu_w_q   <= alu_m_q;
        waddr_w_q <= waddr_m_q;
        if (MemReq && MemReady) rdata_w_q <= ReadData;
      end
    end
  end

  assign ALUResultM = alu_m_q;
  assign WriteAddrM = waddr_m_q;
  assign RegWriteM  = regwrite_m_q;
  assign DataAdr    = alu_m_q;
  assign MemWData   = wdata_m_q;
  assign MemWe      = memwrite_m_q & MemReq;
  assign PCSrcW     = wb_q.pcsrc;
  assign RegWriteW  = wb_q.regwrite;
  assign MemtoRegW  = wb_q.memtoreg;
  assign ReadDataW  = rdata_w_q;
  assign ALUOutW    = alu_w_q;
  assign WriteAddrW = waddr_w_q;
  assign MemFault   = fault_q;

endmodule
